// File: rtl/tensor_dtile_writeback_pkg.sv
// Shared types and parameter helpers for the D-tile writeback path.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

package tensor_dtile_writeback_pkg;

    typedef logic [3:0][3:0][31:0] dtile_t;

    typedef enum logic {StIdle, StDrain} wb_state_e;

    function automatic bit rows_per_beat_legal(input int unsigned rpb);
        return (rpb == 1) || (rpb == 2) || (rpb == 4);
    endfunction

    function automatic int unsigned beat_width(input int unsigned num_beats);
        return (num_beats > 1) ? $clog2(num_beats) : 1;
    endfunction

endpackage

// File: rtl/tensor_wb_beat_ctr.sv
// Beat index counter: advances on enable, wraps to zero after the last beat,
// synchronous clear has priority over enable.
module tensor_wb_beat_ctr #(
    parameter int unsigned NumBeats = 4,
    parameter int unsigned BeatW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [BeatW-1:0] beat_o,
    output logic             last_o
);

    logic [BeatW-1:0] beat_q, beat_d;

    assign last_o = (beat_q == BeatW'(NumBeats - 1));
    assign beat_o = beat_q;

    always_comb begin
        beat_d = beat_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (en_i) begin
            beat_d = last_o ? '0 : beat_q + BeatW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/tensor_dtile_writeback.sv
// Latches one 4x4 FP32 D tile and drains it ROWS_PER_BEAT rows per beat onto the
// commit bus; a new tile may be taken on the cycle the last beat leaves.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tensor_dtile_writeback
    import tensor_dtile_writeback_pkg::*;
#(
    parameter int unsigned  ROWS_PER_BEAT = 1,
    localparam int unsigned NUM_BEATS     = 4 / ROWS_PER_BEAT,
    localparam int unsigned BEAT_W        = beat_width(NUM_BEATS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_in,
    output logic                                  ready_in,
    input  logic [3:0][3:0][31:0]                 D_tile,
    input  logic [`NW_WIDTH-1:0]                  D_wid,
    output logic                                  valid_out,
    input  logic                                  ready_out,
    output logic [ROWS_PER_BEAT-1:0][3:0][31:0]   out_rows,
    output logic [BEAT_W-1:0]                     out_beat,
    output logic                                  out_last,
    output logic [`NW_WIDTH-1:0]                  out_wid,
    output logic [31:0]                           tiles_done
);

    if (!rows_per_beat_legal(ROWS_PER_BEAT)) begin : g_bad_rows_per_beat
        $error("tensor_dtile_writeback: ROWS_PER_BEAT must be 1, 2 or 4");
    end

    wb_state_e              state_q, state_d;
    dtile_t                 tile_q;
    logic [`NW_WIDTH-1:0]   wid_q;
    logic [31:0]            tiles_done_q;
    logic [BEAT_W-1:0]      beat;
    logic                   beat_last;
    logic                   in_fire, out_fire;

    assign valid_out = (state_q == StDrain);
    // Gate with state so a single-beat configuration still reads 0 while idle.
    assign out_last  = valid_out && beat_last;
    assign out_fire  = valid_out && ready_out;
    assign ready_in  = (state_q == StIdle) || (out_fire && out_last);
    assign in_fire   = valid_in && ready_in;

    assign out_beat   = beat;
    assign out_wid    = wid_q;
    assign tiles_done = tiles_done_q;

    tensor_wb_beat_ctr #(
        .NumBeats (NUM_BEATS),
        .BeatW    (BEAT_W)
    ) u_beat_ctr (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (out_fire),
        .clr_i  (in_fire),
        .beat_o (beat),
        .last_o (beat_last)
    );

    always_comb begin
        out_rows = '0;
        for (int unsigned r = 0; r < ROWS_PER_BEAT; r++) begin
            out_rows[r] = tile_q[2'(32'(beat) * ROWS_PER_BEAT + r)];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_fire) state_d = StDrain;
            end
            StDrain: begin
                if (out_fire && out_last) state_d = in_fire ? StDrain : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tile_q       <= '0;
            wid_q        <= '0;
            tiles_done_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                tile_q <= D_tile;
                wid_q  <= D_wid;
            end
            if (out_fire && out_last) tiles_done_q <= tiles_done_q + 32'd1;
        end
    end

    a_no_valid_in_idle: assert property (@(posedge clk) disable iff (!reset)
        !(state_q == StIdle && valid_out));

endmodule

// File: tb/tb_tensor_dtile_writeback.sv
// Drives three writeback instances (1, 2 and 4 rows per beat) from shared inputs and
// compares every output against a beat-queue reference model each cycle.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module tb_tensor_dtile_writeback;

    localparam int NW = `NW_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   valid_in = 1'b0;
    logic                   ready_out = 1'b0;
    logic [3:0][3:0][31:0]  d_tile = '0;
    logic [NW-1:0]          d_wid = '0;

    always #5 clk = ~clk;

    logic [2:0]             rdy_v, vld_v, last_v;
    logic [0:0][3:0][31:0]  rows0;
    logic [1:0][3:0][31:0]  rows1;
    logic [3:0][3:0][31:0]  rows2;
    logic [1:0]             beat0;
    logic [0:0]             beat1, beat2;
    logic [NW-1:0]          wid0, wid1, wid2;
    logic [31:0]            done0, done1, done2;

    tensor_dtile_writeback #(.ROWS_PER_BEAT(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .valid_in(valid_in), .ready_in(rdy_v[0]),
        .D_tile(d_tile), .D_wid(d_wid), .valid_out(vld_v[0]), .ready_out(ready_out),
        .out_rows(rows0), .out_beat(beat0), .out_last(last_v[0]), .out_wid(wid0),
        .tiles_done(done0)
    );
    tensor_dtile_writeback #(.ROWS_PER_BEAT(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .valid_in(valid_in), .ready_in(rdy_v[1]),
        .D_tile(d_tile), .D_wid(d_wid), .valid_out(vld_v[1]), .ready_out(ready_out),
        .out_rows(rows1), .out_beat(beat1), .out_last(last_v[1]), .out_wid(wid1),
        .tiles_done(done1)
    );
    tensor_dtile_writeback #(.ROWS_PER_BEAT(4)) u_dut2 (
        .clk(clk), .reset(rst_n), .valid_in(valid_in), .ready_in(rdy_v[2]),
        .D_tile(d_tile), .D_wid(d_wid), .valid_out(vld_v[2]), .ready_out(ready_out),
        .out_rows(rows2), .out_beat(beat2), .out_last(last_v[2]), .out_wid(wid2),
        .tiles_done(done2)
    );

    logic [511:0]   rows_a [3];
    logic [1:0]     beat_a [3];
    logic [NW-1:0]  wid_a  [3];
    logic [31:0]    done_a [3];

    always_comb begin
        rows_a[0] = 512'(rows0);
        rows_a[1] = 512'(rows1);
        rows_a[2] = 512'(rows2);
        beat_a[0] = beat0;
        beat_a[1] = 2'(beat1);
        beat_a[2] = 2'(beat2);
        wid_a[0]  = wid0;
        wid_a[1]  = wid1;
        wid_a[2]  = wid2;
        done_a[0] = done0;
        done_a[1] = done1;
        done_a[2] = done2;
    end

    // Reference: per instance, the queue of beats still owed for the accepted tile.
    typedef struct packed {
        logic [511:0]  rows;
        logic [1:0]    beat;
        logic          last;
        logic [NW-1:0] wid;
    } exp_beat_t;

    exp_beat_t exp_q [3][8];
    int        exp_cnt  [3];
    int        exp_hd   [3];
    int        exp_done [3];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [511:0] got,
                             input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rpb_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            exp_cnt[k]  = 0;
            exp_hd[k]   = 0;
            exp_done[k] = 0;
        end
    endtask

    task automatic model_step();
        logic         exp_valid, exp_rdy;
        exp_beat_t    e;
        logic [511:0] mask;
        int           rpb, nb;
        for (int k = 0; k < 3; k++) begin
            rpb       = rpb_of(k);
            nb        = 4 / rpb;
            exp_valid = (exp_cnt[k] != 0);
            exp_rdy   = (exp_cnt[k] == 0) || (exp_cnt[k] == 1 && ready_out);
            check_val($sformatf("d%0d.valid_out", k), 512'(vld_v[k]), 512'(exp_valid));
            check_val($sformatf("d%0d.ready_in", k), 512'(rdy_v[k]), 512'(exp_rdy));
            check_val($sformatf("d%0d.tiles_done", k), 512'(done_a[k]),
                      512'(32'(exp_done[k])));
            if (!rst_n) begin
                check_val($sformatf("d%0d.rst_rows", k), rows_a[k], '0);
                check_val($sformatf("d%0d.rst_beat", k), 512'(beat_a[k]), '0);
                check_val($sformatf("d%0d.rst_last", k), 512'(last_v[k]), '0);
                check_val($sformatf("d%0d.rst_wid", k), 512'(wid_a[k]), '0);
            end
            if (exp_valid) begin
                e = exp_q[k][exp_hd[k]];
                check_val($sformatf("d%0d.out_rows", k), rows_a[k], e.rows);
                check_val($sformatf("d%0d.out_beat", k), 512'(beat_a[k]), 512'(e.beat));
                check_val($sformatf("d%0d.out_last", k), 512'(last_v[k]), 512'(e.last));
                check_val($sformatf("d%0d.out_wid", k), 512'(wid_a[k]), 512'(e.wid));
            end
            if (rst_n) begin
                if (exp_valid && ready_out) begin
                    if (exp_q[k][exp_hd[k]].last) exp_done[k]++;
                    exp_hd[k] = (exp_hd[k] + 1) % 8;
                    exp_cnt[k]--;
                end
                if (valid_in && exp_rdy) begin
                    mask = (512'(1) << (rpb * 128)) - 512'(1);
                    for (int b = 0; b < nb; b++) begin
                        e.rows = (512'(d_tile) >> (b * rpb * 128)) & mask;
                        e.beat = 2'(b);
                        e.last = (b == nb - 1);
                        e.wid  = d_wid;
                        exp_q[k][(exp_hd[k] + exp_cnt[k]) % 8] = e;
                        exp_cnt[k]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_tile();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                d_tile[r][c] = $urandom();
        d_wid = NW'($urandom());
    endtask

    initial begin
        int base;
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;

        // Single tile with the r*16+c pattern
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                d_tile[r][c] = 32'(r * 16 + c);
        d_wid     = NW'(3);
        valid_in  = 1'b1;
        ready_out = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (6) tick();
        check_val("single.done0", 512'(done0), 512'(1));

        // Back-to-back with valid_in held high
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_tile();
            d_wid = NW'(i + 1);
            tick();
        end
        valid_in = 1'b0;
        repeat (5) tick();

        // Backpressure mid-drain, with a tile offered during the stall
        rand_tile();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        ready_out = 1'b0;
        rand_tile();
        valid_in = 1'b1;
        repeat (4) tick();
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (6) tick();

        // Full-width streaming: ten tiles
        base     = exp_done[2];
        valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_tile();
            tick();
        end
        valid_in = 1'b0;
        repeat (3) tick();
        check_val("stream.done2", 512'(done2), 512'(32'(base + 10)));

        // Reset during beat 2 of a tile
        rand_tile();
        d_wid    = NW'(7);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("d%0d.rst_now_valid", k), 512'(vld_v[k]), '0);
            check_val($sformatf("d%0d.rst_now_ready", k), 512'(rdy_v[k]), 512'(1));
            check_val($sformatf("d%0d.rst_now_done", k), 512'(done_a[k]), '0);
        end
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        rand_tile();
        d_wid    = NW'(5);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (6) tick();

        // Idle hold
        for (int i = 0; i < 20; i++) begin
            ready_out = $urandom_range(0, 1) == 1;
            rand_tile();
            tick();
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            valid_in  = $urandom_range(0, 99) < 60;
            ready_out = $urandom_range(0, 99) < 70;
            rand_tile();
            tick();
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
